dna_search_engine: RTL and testbench

Parametrised approximate-match search engine for 2-bit-encoded DNA. It loads a sequence window and a key on `start` and slides the key across every base offset, checking `LANES` offsets per cycle through a two-stage compare/accumulate pipeline. A window counts as a hit when its base-mismatch count is ≤ `max_mismatch`. It reports the first hit position, its mismatch count and the total hit count, and supports stop-at-first-hit and scan-all modes. It is the next-generation multi-lane replacement for the fixed 4-comparator exact-match search stage in the matching/variation-detection datapath.

---
 rtl/dna_search_engine.sv | 173 +++++++++++++++++
 tb/tb_dna_search_engine.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dna_search_engine.sv
// Approximate-match DNA key search: LANES offsets per cycle through a compare/accumulate pipeline.
// Latency G+2 cycles (stop-at-first-hit: hit group + 3); start is ignored while busy, outputs hold until next accept.
module dna_search_engine #(
  parameter  int SEQ_BASES = 256,
  parameter  int KEY_BASES = 32,
  parameter  int LANES     = 4,
  parameter  int MW        = 6,
  localparam int N         = SEQ_BASES - KEY_BASES + 1,
  localparam int PW        = $clog2(SEQ_BASES),
  localparam int CW        = $clog2(N + 1)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [2*SEQ_BASES-1:0] seq,
  input  logic [2*KEY_BASES-1:0] key,
  input  logic [MW-1:0]          max_mismatch,
  input  logic                   mode,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [PW-1:0]          first_pos,
  output logic [MW-1:0]          first_mism,
  output logic [CW-1:0]          hit_count
);

  localparam int LN  = (LANES < 1) ? 1 : LANES;
  localparam int G   = (N + LN - 1) / LN;
  localparam int GW  = $clog2(G + 1);
  localparam int LW  = $clog2(LN + 1);
  localparam int PCW = $clog2(G * LN + 1);
  localparam int XB  = SEQ_BASES + LN;
  localparam int SAT = (1 << MW) - 1;

  if (SEQ_BASES < KEY_BASES || LANES < 1) begin : g_bad_params
    $error("dna_search_engine: need SEQ_BASES >= KEY_BASES and LANES >= 1");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [2*XB-1:0]        seq_sh;
  logic [2*KEY_BASES-1:0] key_r;
  logic [MW-1:0]          mm_r;
  logic                   mode_r;
  logic                   stop;
  logic [GW-1:0]          grp;
  logic [PCW-1:0]         pos;

  logic                   s1_vld;
  logic [PCW-1:0]         s1_pos;
  logic [LN-1:0]          s1_lv;
  logic [MW-1:0]          s1_mism [LN];

  logic [MW-1:0]          lane_mism [LN];
  logic [LN-1:0]          lane_ok;
  logic [LN-1:0]          lane_hit;
  logic [LW-1:0]          hit_cnt;
  logic [LW-1:0]          hit_lane;
  logic [MW-1:0]          hit_mism;
  logic                   any_hit;

  // seq_sh is pre-shifted so lane l of the current group always reads bases l..l+KEY_BASES-1
  always_comb begin
    int cnt;
    cnt = 0;
    lane_ok = '0;
    for (int l = 0; l < LN; l++) begin
      cnt = 0;
      for (int j = 0; j < KEY_BASES; j++)
        if (seq_sh[2*(l+j) +: 2] != key_r[2*j +: 2]) cnt = cnt + 1;
      lane_mism[l] = MW'((cnt > SAT) ? SAT : cnt);
      lane_ok[l]   = (int'(pos) + l) < N;
    end
  end

  // Descending scan so the lowest hitting lane is the one left selected
  always_comb begin
    hit_cnt  = '0;
    hit_lane = '0;
    hit_mism = '0;
    any_hit  = 1'b0;
    lane_hit = '0;
    for (int l = LN - 1; l >= 0; l--) begin
      lane_hit[l] = s1_lv[l] && (s1_mism[l] <= mm_r);
      hit_cnt     = hit_cnt + LW'(lane_hit[l]);
      if (lane_hit[l]) begin
        any_hit  = 1'b1;
        hit_lane = LW'(l);
        hit_mism = s1_mism[l];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      found      <= 1'b0;
      first_pos  <= '0;
      first_mism <= '0;
      hit_count  <= '0;
      seq_sh     <= '0;
      key_r      <= '0;
      mm_r       <= '0;
      mode_r     <= 1'b0;
      stop       <= 1'b0;
      grp        <= '0;
      pos        <= '0;
      s1_vld     <= 1'b0;
      s1_pos     <= '0;
      s1_lv      <= '0;
      for (int l = 0; l < LN; l++) s1_mism[l] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        SCAN, DRAIN: begin
          if (state == SCAN && !stop) begin
            s1_vld <= 1'b1;
            s1_pos <= pos;
            s1_lv  <= lane_ok;
            for (int l = 0; l < LN; l++) s1_mism[l] <= lane_mism[l];
            seq_sh <= seq_sh >> (2*LN);
            pos    <= pos + PCW'(LN);
            grp    <= grp + 1'b1;
          end else begin
            s1_vld <= 1'b0;
          end
          // Once stop is set, anything still in stage 1 belongs to a later group and is dropped
          if (s1_vld && !stop) begin
            hit_count <= hit_count + CW'(hit_cnt);
            if (any_hit && !found) begin
              found      <= 1'b1;
              first_pos  <= PW'(s1_pos + PCW'(hit_lane));
              first_mism <= hit_mism;
            end
            if (any_hit && mode_r) stop <= 1'b1;
          end
          if (stop || (state == DRAIN && !s1_vld)) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            s1_vld <= 1'b0;
          end else if (state == SCAN && grp == GW'(G - 1)) begin
            state <= DRAIN;
          end
        end
        default: begin
          s1_vld <= 1'b0;
          if (start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            seq_sh     <= {{(2*LN){1'b0}}, seq};
            key_r      <= key;
            mm_r       <= max_mismatch;
            mode_r     <= mode;
            stop       <= 1'b0;
            grp        <= '0;
            pos        <= '0;
            found      <= 1'b0;
            first_pos  <= '0;
            first_mism <= '0;
            hit_count  <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dna_search_engine.sv
// Bench for dna_search_engine: three lane configurations share stimulus, checked against a position-level model.
module tb_dna_search_engine;

  localparam int SB = 256;
  localparam int KB = 32;
  localparam int MW = 6;
  localparam int N  = SB - KB + 1;

  logic            clock = 1'b0;
  logic            reset_n;
  logic            start;
  logic [2*SB-1:0] seq;
  logic [2*KB-1:0] key;
  logic [MW-1:0]   max_mismatch;
  logic            mode;

  logic            busy_v  [3];
  logic            done_v  [3];
  logic            found_v [3];
  logic [7:0]      fpos_v  [3];
  logic [MW-1:0]   fmism_v [3];
  logic [7:0]      hcnt_v  [3];

  int checks = 0;
  int errors = 0;
  bit armed  [3];
  bit rvalid [3];
  int cnt    [3];
  int e_found[3], e_pos[3], e_mism[3], e_cnt[3], e_lat[3];
  int r_found[3], r_pos[3], r_mism[3], r_cnt[3], r_lat[3];

  always #5 clock = ~clock;

  dna_search_engine #(.SEQ_BASES(SB), .KEY_BASES(KB), .LANES(4), .MW(MW)) u_l4 (
    .clock(clock), .reset_n(reset_n), .start(start), .seq(seq), .key(key),
    .max_mismatch(max_mismatch), .mode(mode), .busy(busy_v[0]), .done(done_v[0]),
    .found(found_v[0]), .first_pos(fpos_v[0]), .first_mism(fmism_v[0]), .hit_count(hcnt_v[0]));

  dna_search_engine #(.SEQ_BASES(SB), .KEY_BASES(KB), .LANES(1), .MW(MW)) u_l1 (
    .clock(clock), .reset_n(reset_n), .start(start), .seq(seq), .key(key),
    .max_mismatch(max_mismatch), .mode(mode), .busy(busy_v[1]), .done(done_v[1]),
    .found(found_v[1]), .first_pos(fpos_v[1]), .first_mism(fmism_v[1]), .hit_count(hcnt_v[1]));

  dna_search_engine #(.SEQ_BASES(SB), .KEY_BASES(KB), .LANES(7), .MW(MW)) u_l7 (
    .clock(clock), .reset_n(reset_n), .start(start), .seq(seq), .key(key),
    .max_mismatch(max_mismatch), .mode(mode), .busy(busy_v[2]), .done(done_v[2]),
    .found(found_v[2]), .first_pos(fpos_v[2]), .first_mism(fmism_v[2]), .hit_count(hcnt_v[2]));

  function automatic int lanes_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 1 : 7;
  endfunction

  task automatic chk(input int k, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL lanes%0d %s: got %0d want %0d", lanes_of(k), nm, act, exp);
    end
  endtask

  // Score every position, then apply the group/stop rules on top of the per-position list
  function automatic void model(input int lanes, input int mx, input bit md,
                                output int f, output int fp, output int fm,
                                output int hc, output int lat);
    int m[N];
    int g, hi;
    f = 0; fp = 0; fm = 0; hc = 0;
    for (int p = 0; p < N; p++) begin
      m[p] = 0;
      for (int j = 0; j < KB; j++)
        if (seq[2*(p+j) +: 2] != key[2*j +: 2]) m[p]++;
      if (m[p] > (1 << MW) - 1) m[p] = (1 << MW) - 1;
    end
    for (int p = 0; p < N; p++)
      if (m[p] <= mx) begin
        hc++;
        if (f == 0) begin f = 1; fp = p; fm = m[p]; end
      end
    lat = (N + lanes - 1) / lanes + 2;
    if (md && f != 0) begin
      g  = fp / lanes;
      hi = (g + 1) * lanes;
      if (hi > N) hi = N;
      hc = 0;
      for (int p = g * lanes; p < hi; p++)
        if (m[p] <= mx) hc++;
      lat = g + 3;
    end
  endfunction

  task automatic tick();
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        chk(k, "reset_outputs", int'({busy_v[k], done_v[k], found_v[k], fpos_v[k], fmism_v[k], hcnt_v[k]}), 0);
        armed[k]  = 1'b0;
        rvalid[k] = 1'b0;
      end else if (armed[k]) begin
        cnt[k]++;
        if (done_v[k]) begin
          chk(k, "latency", cnt[k], e_lat[k]);
          chk(k, "busy_at_done", busy_v[k], 0);
          chk(k, "found", found_v[k], e_found[k]);
          chk(k, "first_pos", fpos_v[k], e_pos[k]);
          chk(k, "first_mism", fmism_v[k], e_mism[k]);
          chk(k, "hit_count", hcnt_v[k], e_cnt[k]);
          r_found[k] = found_v[k];
          r_pos[k]   = fpos_v[k];
          r_mism[k]  = fmism_v[k];
          r_cnt[k]   = hcnt_v[k];
          r_lat[k]   = cnt[k];
          armed[k]   = 1'b0;
          rvalid[k]  = 1'b1;
        end else begin
          chk(k, "busy_in_scan", busy_v[k], 1);
        end
      end else if (busy_v[k]) begin
        armed[k]  = 1'b1;
        cnt[k]    = 0;
        rvalid[k] = 1'b0;
      end else if (rvalid[k]) begin
        chk(k, "hold_done_low", done_v[k], 0);
        chk(k, "hold_hit_count", hcnt_v[k], r_cnt[k]);
        chk(k, "hold_first_pos", fpos_v[k], r_pos[k]);
      end
    end
  endtask

  // Starts a search with the current seq/key; optional extra start pulse at scan cycle extra_at
  task automatic run(input int mx, input bit md, input int extra_at);
    bit stuck;
    for (int k = 0; k < 3; k++)
      model(lanes_of(k), mx, md, e_found[k], e_pos[k], e_mism[k], e_cnt[k], e_lat[k]);
    max_mismatch = MW'(mx);
    mode         = md;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 400 && (armed[0] || armed[1] || armed[2]); i++) begin
      start = (i == extra_at);
      tick();
    end
    start = 1'b0;
    stuck = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(k, "finished", armed[k], 0);
      if (armed[k]) stuck = 1'b1;
    end
    if (stuck) begin
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
    end
  endtask

  initial begin
    int p, nmut, idx, mx;
    reset_n      = 1'b0;
    start        = 1'b0;
    seq          = '0;
    key          = '0;
    max_mismatch = '0;
    mode         = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // All A against all A: every position is an exact hit
    seq = '0; key = '0;
    run(0, 1'b0, 0);
    chk(0, "lit_latency", r_lat[0], 59);
    chk(1, "lit_latency", r_lat[1], 227);
    chk(2, "lit_latency", r_lat[2], 35);
    for (int k = 0; k < 3; k++) chk(k, "lit_hits", r_cnt[k], 225);
    chk(0, "lit_found", r_found[0], 1);
    chk(0, "lit_first_pos", r_pos[0], 0);
    chk(0, "lit_first_mism", r_mism[0], 0);

    // One G at base 110 knocks out the 32 windows covering it
    seq[221:220] = 2'b10;
    run(0, 1'b0, 0);
    chk(0, "lit_hits_g110", r_cnt[0], 193);
    chk(0, "lit_pos_g110", r_pos[0], 0);
    run(1, 1'b0, 0);
    chk(0, "lit_hits_g110_max1", r_cnt[0], 225);

    // Key of all G embedded at 150 in all C, stop at first hit
    seq = {SB{2'b01}};
    for (int j = 0; j < KB; j++) seq[2*(150+j) +: 2] = 2'b10;
    key = {KB{2'b10}};
    run(0, 1'b1, 0);
    chk(0, "lit_latency_m1", r_lat[0], 40);
    chk(1, "lit_latency_m1", r_lat[1], 153);
    chk(2, "lit_latency_m1", r_lat[2], 24);
    chk(0, "lit_pos_m1", r_pos[0], 150);
    chk(0, "lit_mism_m1", r_mism[0], 0);
    chk(0, "lit_hits_m1", r_cnt[0], 1);

    // Every window has 32 mismatches: tolerance edge at 31/32
    seq = {SB{2'b01}}; key = '0;
    run(31, 1'b0, 0);
    chk(0, "lit_found_max31", r_found[0], 0);
    chk(0, "lit_hits_max31", r_cnt[0], 0);
    chk(0, "lit_pos_max31", r_pos[0], 0);
    run(32, 1'b0, 0);
    chk(0, "lit_hits_max32", r_cnt[0], 225);
    chk(0, "lit_mism_max32", r_mism[0], 32);

    // Random sequences with a lightly mutated copy of one window as key
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) seq[32*i +: 32] = $urandom;
      p = (r == 0) ? N - 1 : int'($urandom_range(0, N - 1));
      key = seq[2*p +: 2*KB];
      nmut = int'($urandom_range(0, 3));
      for (int i = 0; i < nmut; i++) begin
        idx = int'($urandom_range(0, KB - 1));
        key[2*idx +: 2] = 2'($urandom_range(0, 3));
      end
      mx = int'($urandom_range(0, 3));
      run(mx, (r % 2 == 1), 0);
    end

    // Asynchronous reset in the middle of a scan
    seq = '0; key = '0; max_mismatch = '0; mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++)
      chk(k, "async_reset_outputs", int'({busy_v[k], done_v[k], found_v[k], fpos_v[k], fmism_v[k], hcnt_v[k]}), 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Fresh accept after reset, with a stray start pulse while busy
    run(0, 1'b0, 10);
    chk(0, "lit_latency_after_reset", r_lat[0], 59);
    chk(0, "lit_hits_after_reset", r_cnt[0], 225);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
